// File: rtl/and_or_pkg.sv
// Shared types and constants for the selectable AND/OR unit.
package and_or_pkg;

   localparam int AND_OR_DEFAULT_WIDTH = 4;
   localparam int AND_OR_CNT_WIDTH     = 8;

   typedef enum logic [1:0] {
      OP_IDLE     = 2'b00,
      OP_AND      = 2'b01,
      OP_OR       = 2'b10,
      OP_CONFLICT = 2'b11
   } op_t;

endpackage

// File: rtl/and_or_unit_if.sv
// Operand/result bundle for and_or_unit; conflictCnt exists only when
// AND_OR_CONFLICT_CNT_EN is defined.
interface and_or_unit_if
   import and_or_pkg::*;
#(
   parameter int WIDTH = AND_OR_DEFAULT_WIDTH
);
   logic [WIDTH-1:0] aIn;
   logic [WIDTH-1:0] bIn;
   logic             doAnd;
   logic             doOr;
   logic             isAnd;
   logic [WIDTH-1:0] out;
   logic             opErr;
`ifdef AND_OR_CONFLICT_CNT_EN
   logic [AND_OR_CNT_WIDTH-1:0] conflictCnt;
`endif

   modport master (
      output aIn, bIn, doAnd, doOr,
`ifdef AND_OR_CONFLICT_CNT_EN
      input  conflictCnt,
`endif
      input  isAnd, out, opErr
   );

   modport slave (
      input  aIn, bIn, doAnd, doOr,
`ifdef AND_OR_CONFLICT_CNT_EN
      output conflictCnt,
`endif
      output isAnd, out, opErr
   );
endinterface

// File: rtl/and_or_opdec.sv
// Combinational decode of the two request strobes into an operation code.
module and_or_opdec
   import and_or_pkg::*;
(
   input  logic doAnd,
   input  logic doOr,
   output op_t  op
);

   always_comb begin
      op = OP_IDLE;
      case ({doAnd, doOr})
         2'b10:   op = OP_AND;
         2'b01:   op = OP_OR;
         2'b11:   op = OP_CONFLICT;
         default: op = OP_IDLE;
      endcase
   end

endmodule

// File: rtl/and_or_unit.sv
// Registered bitwise AND/OR unit with conflict flag. Optional saturating
// conflict counter under AND_OR_CONFLICT_CNT_EN.
module and_or_unit
   import and_or_pkg::*;
#(
   parameter int WIDTH = AND_OR_DEFAULT_WIDTH
)
(
   input logic         clk,
   input logic         rst,
   and_or_unit_if.slave bus
);

   op_t              op;
   logic [WIDTH-1:0] nxt_out;
   logic             nxt_is_and;
   logic             nxt_op_err;

   and_or_opdec u_opdec (
      .doAnd (bus.doAnd),
      .doOr  (bus.doOr),
      .op    (op)
   );

   // Idle and conflict both force a zero result; nothing is held over.
   always_comb begin
      nxt_out    = '0;
      nxt_is_and = 1'b0;
      nxt_op_err = 1'b0;
      case (op)
         OP_AND: begin
            nxt_out    = bus.aIn & bus.bIn;
            nxt_is_and = 1'b1;
         end
         OP_OR:       nxt_out    = bus.aIn | bus.bIn;
         OP_CONFLICT: nxt_op_err = 1'b1;
         default:     nxt_out    = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.out   <= '0;
         bus.isAnd <= 1'b0;
         bus.opErr <= 1'b0;
      end else begin
         bus.out   <= nxt_out;
         bus.isAnd <= nxt_is_and;
         bus.opErr <= nxt_op_err;
      end
   end

`ifdef AND_OR_CONFLICT_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.conflictCnt <= '0;
      end else if (op == OP_CONFLICT && bus.conflictCnt != '1) begin
         bus.conflictCnt <= bus.conflictCnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_and_or_unit.sv
// Scoreboard bench for and_or_unit: driver pushes expected results, monitor pops and compares.
module tb_and_or_unit;
   localparam int W = 4;

   typedef struct {
      logic [W-1:0] out;
      logic         is_and;
      logic         op_err;
      int           cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   model_cnt = 0;
   exp_t q[$];

   and_or_unit_if #(.WIDTH(W)) bus ();

   and_or_unit #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic da, input logic db);
      exp_t e;
      e.out = '0;
      e.is_and = 1'b0;
      e.op_err = 1'b0;
      if (da && db) begin
         e.op_err = 1'b1;
         if (model_cnt < 255) model_cnt++;
      end else if (da) begin
         for (int i = 0; i < W; i++) e.out[i] = a[i] && b[i];
         e.is_and = 1'b1;
      end else if (db) begin
         for (int i = 0; i < W; i++) e.out[i] = a[i] || b[i];
      end
      e.cnt = model_cnt;
      return e;
   endfunction

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic da, input logic db);
      @(negedge clk);
      bus.aIn = a;
      bus.bIn = b;
      bus.doAnd = da;
      bus.doOr = db;
      q.push_back(model(a, b, da, db));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_out"}, 64'(bus.out), 64'd0);
      chk({tag, "_isand"}, 64'(bus.isAnd), 64'd0);
      chk({tag, "_operr"}, 64'(bus.opErr), 64'd0);
`ifdef AND_OR_CONFLICT_CNT_EN
      chk({tag, "_cnt"}, 64'(bus.conflictCnt), 64'd0);
`endif
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (!rst && q.size() > 0) begin
            e = q.pop_front();
            chk("out", 64'(bus.out), 64'(e.out));
            chk("isAnd", 64'(bus.isAnd), 64'(e.is_and));
            chk("opErr", 64'(bus.opErr), 64'(e.op_err));
`ifdef AND_OR_CONFLICT_CNT_EN
            chk("conflictCnt", 64'(bus.conflictCnt), 64'(e.cnt));
`endif
         end
      end
   end

   initial begin : driver
      int wait_cycles;
      logic sel;
      bus.aIn = '0;
      bus.bIn = '0;
      bus.doAnd = 1'b0;
      bus.doOr = 1'b0;

      #2 rst = 1'b1;
      #1 chk_zero("rst_async");
      @(negedge clk) chk_zero("rst_hold1");
      @(negedge clk) chk_zero("rst_hold2");
      rst = 1'b0;
      model_cnt = 0;

      issue(4'b0101, 4'b0011, 1'b1, 1'b0);
      issue(4'b0101, 4'b0011, 1'b0, 1'b1);
      issue(4'b1111, 4'b1111, 1'b1, 1'b1);
      issue(4'b1100, 4'b1010, 1'b1, 1'b0);
      issue(4'b1100, 4'b1010, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         sel = (i % 2) == 0;
         issue(W'($urandom), W'($urandom), sel, !sel);
      end
      for (int i = 0; i < 200; i++)
         issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      for (int i = 0; i < 300; i++)
         issue(W'($urandom), W'($urandom), 1'b1, 1'b1);
      issue(4'b0110, 4'b0011, 1'b0, 1'b0);

      // Mid-stream reset with an OR pending; it must be discarded.
      @(negedge clk);
      bus.aIn = 4'b1000;
      bus.bIn = 4'b0001;
      bus.doAnd = 1'b0;
      bus.doOr = 1'b1;
      #2 rst = 1'b1;
      q.delete();
      model_cnt = 0;
      #1 chk_zero("rst_mid");
      @(negedge clk) chk_zero("rst_mid_hold1");
      @(negedge clk) chk_zero("rst_mid_hold2");
      rst = 1'b0;
      q.push_back(model(4'b1000, 4'b0001, 1'b0, 1'b1));
      issue(4'b1111, 4'b1111, 1'b1, 1'b1);
      for (int i = 0; i < 20; i++)
         issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));

      wait_cycles = 0;
      while (q.size() > 0 && wait_cycles < 10) begin
         @(negedge clk);
         wait_cycles++;
      end
      chk("drain", 64'(q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
